// File: rtl/user_core_pkg.sv
// Shared types for the lane-parallel user core.
// State and transform-mode encodings plus the progress width helper.
package user_core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } core_state_t;

    typedef enum logic [1:0] {
        M_PASS,
        M_INV,
        M_LSHIFT,
        M_BSWAP
    } xform_mode_t;

    function automatic int prog_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/user_core_xform_lane.sv
// One-word combinational byte transform used by each lane of the core.
// Selects pass, invert, level shift (byte XOR 0x80) or byte swap.
module user_core_xform_lane
    import user_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int NB = DATA_WIDTH / 8;

    always_comb begin
        dout = din;
        unique case (xform_mode_t'(mode))
            M_PASS:   dout = din;
            M_INV:    dout = ~din;
            M_LSHIFT: dout = din ^ {NB{8'h80}};
            M_BSWAP: begin
                for (int b = 0; b < NB; b++) begin
                    dout[b*8 +: 8] = din[(NB-1-b)*8 +: 8];
                end
            end
            default:  dout = din;
        endcase
    end

endmodule

// File: rtl/user_core_lane_xform.sv
// LANES-wide start/busy/done buffer transform core with abort and progress.
// Optional XOR checksum of result words: define USER_CORE_CHECKSUM_EN.
module user_core_lane_xform
    import user_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int LANES      = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [1:0]                         mode,
    input  logic [DATA_WIDTH*DEPTH-1:0]        in_buf,
    output logic [DATA_WIDTH*DEPTH-1:0]        out_buf,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [prog_width(DEPTH)-1:0]       progress,
    output logic [DATA_WIDTH-1:0]              checksum
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = prog_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - LANES);
    localparam logic [PW-1:0] STEP = PW'(LANES);

    core_state_t   state_q, state_d;
    logic [PW-1:0] idx_q;
    logic [1:0]    mode_q;
    logic          err_q;
    logic          load, step, abort_hit;

    logic [DW-1:0] lane_in  [LANES];
    logic [DW-1:0] lane_out [LANES];

    // idx_q doubles as the progress count: both advance by LANES per RUN cycle
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_in[k] = in_buf[(int'(idx_q) + k)*DW +: DW];

        user_core_xform_lane #(
            .DATA_WIDTH(DW)
        ) u_lane (
            .mode(mode_q),
            .din (lane_in[k]),
            .dout(lane_out[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        abort_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                // abort pre-empts this cycle's lane writes
                if (abort) begin
                    state_d   = IDLE;
                    abort_hit = 1'b1;
                end else begin
                    step = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            mode_q  <= 2'b00;
            err_q   <= 1'b0;
            out_buf <= '0;
        end else begin
            if (load) begin
                idx_q  <= '0;
                mode_q <= mode;
                err_q  <= 1'b0;
            end
            if (step) begin
                for (int j = 0; j < LANES; j++) begin
                    out_buf[(int'(idx_q) + j)*DW +: DW] <= lane_out[j];
                end
                idx_q <= idx_q + STEP;
            end
            if (abort_hit) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef USER_CORE_CHECKSUM_EN
    logic [DW-1:0] lane_x;
    logic [DW-1:0] csum_q;

    always_comb begin
        lane_x = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_x = lane_x ^ lane_out[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (load) begin
            csum_q <= '0;
        end else if (step) begin
            csum_q <= csum_q ^ lane_x;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign busy     = (state_q == RUN);
    assign done     = (state_q == FIN);
    assign err      = err_q;
    assign progress = idx_q;

endmodule
